// File: rtl/counter_ctrl.sv
// counter_ctrl: command-driven sequencer for the interval counter with shadow tic and auto-halt at limit
module counter_ctrl #(
  parameter int                CNT_W        = 32,
  parameter logic [CNT_W-1:0]  DEF_INTERVAL = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_data,
  input  logic [CNT_W-1:0] counter_val,
  output logic [7:0]       state,
  output logic [CNT_W-1:0] interval,
  output logic             running,
  output logic             done,
  output logic             cmd_err
);

  localparam logic [1:0] S_CLR  = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [2:0] OP_CLEAR = 3'd0;
  localparam logic [2:0] OP_START = 3'd1;
  localparam logic [2:0] OP_STOP  = 3'd2;
  localparam logic [2:0] OP_SETIV = 3'd3;
  localparam logic [2:0] OP_SETLM = 3'd4;

  logic [1:0]       fsm, fsm_nxt;
  logic [CNT_W-1:0] limit, tic;
  logic             accept, in_run, is_clear, tic_hit, at_limit, set_op, bad_cmd;

  assign accept   = cmd_valid & cmd_ready;
  assign in_run   = (fsm == S_RUN);
  assign is_clear = accept && (cmd_op == OP_CLEAR);
  assign set_op   = (cmd_op == OP_SETIV) || (cmd_op == OP_SETLM);
  assign tic_hit  = in_run && (tic == interval);
  // The counter reaches limit on this very edge; halting now keeps it from ever passing limit.
  assign at_limit = tic_hit && (limit != '0) && (counter_val + CNT_W'(1) == limit);
  assign bad_cmd  = accept && ((set_op && in_run) || (cmd_op > OP_SETLM));
  assign state    = {6'd0, fsm};

  // Next FSM state; later assignments take priority (CLEAR beats auto-halt beats START/STOP).
  always_comb begin
    fsm_nxt = fsm;
    if (accept && cmd_op == OP_START && !in_run) fsm_nxt = S_RUN;
    if (accept && cmd_op == OP_STOP && in_run) fsm_nxt = S_HALT;
    if (at_limit) fsm_nxt = S_HALT;
    if (is_clear) fsm_nxt = S_CLR;
  end

  // FSM, status pulses and command readiness.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm       <= S_CLR;
      running   <= 1'b0;
      done      <= 1'b0;
      cmd_err   <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      fsm       <= fsm_nxt;
      running   <= (fsm_nxt == S_RUN);
      done      <= at_limit && !is_clear;
      cmd_err   <= bad_cmd;
      cmd_ready <= 1'b1;
    end
  end

  // Interval and limit are only writable outside RUN so the shadow tic stays in lockstep.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      interval <= DEF_INTERVAL;
      limit    <= '0;
    end else if (accept && !in_run) begin
      if (cmd_op == OP_SETIV) interval <= cmd_data;
      if (cmd_op == OP_SETLM) limit <= cmd_data;
    end
  end

  // Shadow of the counter's tic, driven by the state code the counter sees this cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tic <= '0;
    else if (fsm == S_CLR) tic <= '0;
    else if (in_run) tic <= tic_hit ? '0 : tic + CNT_W'(1);
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed bench for counter_ctrl with a behavioural interval counter in the loop
module tb_counter_ctrl;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [31:0] cmd_data = 32'd0;
  logic [31:0] counter_val;
  logic [7:0]  state;
  logic [31:0] interval;
  logic        running, done, cmd_err;
  logic [31:0] ctic;
  int checks = 0;
  int failures = 0;

  counter_ctrl #(.CNT_W(32), .DEF_INTERVAL(32'd0)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .counter_val(counter_val),
    .state(state), .interval(interval), .running(running), .done(done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // Behavioural interval counter block driven by the controller outputs.
  initial begin
    counter_val = 32'd0;
    ctic = 32'd0;
  end
  always @(posedge clk) begin
    if (state == 8'd0) begin
      ctic <= 32'd0;
      counter_val <= 32'd0;
    end else if (state == 8'd1) begin
      if (ctic == interval) begin
        ctic <= 32'd0;
        counter_val <= counter_val + 32'd1;
      end else ctic <= ctic + 32'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the command is accepted at the next posedge and we return at the following negedge.
  task automatic cmd(input logic [2:0] op, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = data;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    idle(3);
    chk("rst_state", state, 0);
    chk("rst_interval", interval, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cmd_err, 0);
    resetn = 1'b1;
    idle(1);
    chk("ready_after_edge", cmd_ready, 1);
    chk("idle_state", state, 0);

    // Interval 3: one increment per 4 cycles.
    cmd(3'd3, 32'd3);
    chk("iv3_loaded", interval, 3);
    cmd(3'd1, 32'd0);
    chk("start_state", state, 1);
    chk("start_running", running, 1);
    idle(20);
    cmd(3'd2, 32'd0);
    chk("stop_state", state, 2);
    chk("stop_running", running, 0);
    chk("stop_count", counter_val, 5);
    idle(10);
    chk("halt_hold_count", counter_val, 5);
    cmd(3'd5, 32'd0);
    chk("reserved_err", cmd_err, 1);
    chk("reserved_state", state, 2);
    idle(1);
    chk("reserved_err_pulse", cmd_err, 0);

    // Auto-halt at limit 7 with interval 0.
    cmd(3'd0, 32'd0);
    chk("clear_state", state, 0);
    cmd(3'd3, 32'd0);
    cmd(3'd4, 32'd7);
    idle(1);
    chk("cleared_count", counter_val, 0);
    cmd(3'd1, 32'd0);
    idle(6);
    chk("pre_limit_count", counter_val, 6);
    chk("pre_limit_state", state, 1);
    chk("pre_limit_done", done, 0);
    idle(1);
    chk("limit_count", counter_val, 7);
    chk("limit_state", state, 2);
    chk("limit_done", done, 1);
    idle(1);
    chk("done_pulse_end", done, 0);
    idle(10);
    chk("limit_hold", counter_val, 7);

    // Interval change rejected in RUN; rate unchanged.
    cmd(3'd0, 32'd0);
    cmd(3'd3, 32'd1);
    cmd(3'd4, 32'd0);
    cmd(3'd1, 32'd0);
    cmd(3'd3, 32'd9);
    chk("run_set_err", cmd_err, 1);
    chk("run_set_interval", interval, 1);
    chk("run_set_count0", counter_val, 0);
    idle(1);
    chk("run_set_err_pulse", cmd_err, 0);
    chk("rate_count1", counter_val, 1);
    idle(8);
    chk("rate_count5", counter_val, 5);
    cmd(3'd1, 32'd0);
    chk("start_in_run_err", cmd_err, 0);
    chk("start_in_run_state", state, 1);

    // Auto-halt coincident with CLEAR.
    cmd(3'd0, 32'd0);
    cmd(3'd3, 32'd0);
    cmd(3'd4, 32'd3);
    cmd(3'd1, 32'd0);
    idle(2);
    cmd(3'd0, 32'd0);
    chk("clr_coinc_state", state, 0);
    chk("clr_coinc_done", done, 0);
    idle(1);
    chk("clr_coinc_done2", done, 0);
    idle(1);
    chk("clr_coinc_count", counter_val, 0);

    // Auto-halt coincident with STOP.
    cmd(3'd1, 32'd0);
    idle(2);
    cmd(3'd2, 32'd0);
    chk("stop_coinc_state", state, 2);
    chk("stop_coinc_done", done, 1);
    chk("stop_coinc_count", counter_val, 3);
    idle(1);
    chk("stop_coinc_pulse", done, 0);
    chk("stop_coinc_hold", counter_val, 3);

    // Reset in the middle of a RUN.
    cmd(3'd0, 32'd0);
    cmd(3'd3, 32'd2);
    cmd(3'd4, 32'd0);
    cmd(3'd1, 32'd0);
    idle(13);
    chk("mid_run_count", counter_val, 4);
    resetn = 1'b0;
    #1;
    chk("async_state", state, 0);
    chk("async_running", running, 0);
    chk("async_interval", interval, 0);
    chk("async_ready", cmd_ready, 0);
    chk("async_count_held", counter_val, 4);
    idle(1);
    chk("reset_clears_count", counter_val, 0);
    resetn = 1'b1;
    idle(1);
    chk("ready_again", cmd_ready, 1);
    cmd(3'd1, 32'd0);
    chk("restart_state", state, 1);
    chk("restart_count0", counter_val, 0);
    idle(1);
    chk("restart_count1", counter_val, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
